inst_buffer: RTL and testbench

- Decoupling instruction queue between the fetch stage (IF) and the decode stage (ID).
- Accepts fetch packets {excp_en, excp_num, pc, inst} from IF and presents them in order to ID.
- Absorbs ID back-pressure so IF can keep issuing fetches.
- Flushed wholesale on branch redirect, exception entry or ertn.

---
 rtl/inst_buffer_pkg.sv | 15 +
 rtl/inst_buffer_if.sv | 24 ++
 rtl/inst_buffer.sv | 82 ++++++++
 tb/tb_inst_buffer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared sizing and packet layout for the IF->ID instruction buffer.
// The fetch packet carries the exception tag alongside pc and instruction.
package inst_buffer_pkg;

  localparam int IF_TO_ID_BUS_SIZE = 66;
  localparam int IB_DEPTH          = 4;

  typedef struct packed {
    logic        excp_en;
    logic        excp_num;
    logic [31:0] pc;
    logic [31:0] inst;
  } ib_pkt_t;

endpackage

// File: rtl/inst_buffer_if.sv
// IF/ID handshake bundle seen by the instruction buffer.
// The buffer takes the slave view; the fetch/decode side takes the master view.
interface inst_buffer_if
  import inst_buffer_pkg::*;
#(
  parameter int BUS_W = IF_TO_ID_BUS_SIZE
);
  logic             IF_to_ID_Valid;
  logic [BUS_W-1:0] IF_to_ID_Bus;
  logic             IB_Allow_in;
  logic             IB_to_ID_Valid;
  logic [BUS_W-1:0] IB_to_ID_Bus;
  logic             ID_Allow_in;

  modport slave (
    input  IF_to_ID_Valid, IF_to_ID_Bus, ID_Allow_in,
    output IB_Allow_in, IB_to_ID_Valid, IB_to_ID_Bus
  );

  modport master (
    output IF_to_ID_Valid, IF_to_ID_Bus, ID_Allow_in,
    input  IB_Allow_in, IB_to_ID_Valid, IB_to_ID_Bus
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular FIFO decoupling fetch from decode; any redirect or exception
// flush empties it in one cycle. Payload is opaque to the buffer.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int BUS_W = IF_TO_ID_BUS_SIZE,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  inst_buffer_if.slave     ib,
  input  logic             br_taken,
  input  logic             excp_flush,
  input  logic             ertn_flush,
  output logic [CNT_W-1:0] IB_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BUS_W-1:0] mem_q [DEPTH];
  logic [BUS_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic flush, full, empty, push, pop;

  always_comb begin
    flush = br_taken | excp_flush | ertn_flush;
    full  = (cnt_q == CNT_W'(DEPTH));
    empty = (cnt_q == '0);
    // Allow depends only on occupancy, so fetch never sees a path from ID or flush.
    push  = ib.IF_to_ID_Valid & ~full & ~flush;
    pop   = ~empty & ib.ID_Allow_in & ~flush;

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;

    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = ib.IF_to_ID_Bus;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; stale entries are masked by the occupancy count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ib.IB_Allow_in    = ~full;
  assign ib.IB_to_ID_Valid = ~empty;
  assign ib.IB_to_ID_Bus   = mem_q[rptr_q];
  assign IB_count          = cnt_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: a queue model of the FIFO tracks accepted
// packets; the monitor checks head, valid, allow and count on every falling edge.
module tb_inst_buffer;

  localparam int DEPTH = 4;
  localparam int BUS_W = 66;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic br_taken = 1'b0, excp_flush = 1'b0, ertn_flush = 1'b0;
  logic [CNT_W-1:0] IB_count;

  inst_buffer_if #(.BUS_W(BUS_W)) ib ();

  inst_buffer #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ib         (ib.slave),
    .br_taken   (br_taken),
    .excp_flush (excp_flush),
    .ertn_flush (ertn_flush),
    .IB_count   (IB_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BUS_W-1:0] model_q [$];
  bit started = 0;

  function automatic logic [BUS_W-1:0] pkt(bit e, bit n, logic [31:0] pc, logic [31:0] inst);
    return {e, n, pc, inst};
  endfunction

  task automatic chk(string name, logic [BUS_W-1:0] act, logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: compare against model, then advance model using
  // the inputs that will be sampled at the next rising edge.
  always @(negedge clk) begin
    bit do_push, do_pop, do_flush;
    int sz;
    sz = model_q.size();
    if (started) begin
      chk("count", BUS_W'(IB_count), BUS_W'(sz));
      chk("allow_in", BUS_W'(ib.IB_Allow_in), BUS_W'(sz < DEPTH));
      chk("valid", BUS_W'(ib.IB_to_ID_Valid), BUS_W'(sz != 0));
      if (sz != 0) chk("head", ib.IB_to_ID_Bus, model_q[0]);
    end
    do_flush = br_taken | excp_flush | ertn_flush;
    if (!resetn || do_flush) begin
      model_q.delete();
    end else begin
      do_pop  = (sz != 0) && ib.ID_Allow_in;
      do_push = ib.IF_to_ID_Valid && (sz < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(ib.IF_to_ID_Bus);
    end
  end

  initial begin
    @(posedge clk);
    started = 1;
  end

  task automatic step(bit v, logic [BUS_W-1:0] b, bit a,
                      bit br = 0, bit ex = 0, bit er = 0, bit rst_n = 1);
    ib.IF_to_ID_Valid = v;
    ib.IF_to_ID_Bus   = b;
    ib.ID_Allow_in    = a;
    br_taken          = br;
    excp_flush        = ex;
    ertn_flush        = er;
    resetn            = rst_n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    ib.IF_to_ID_Valid = 1'b0;
    ib.IF_to_ID_Bus   = '0;
    ib.ID_Allow_in    = 1'b0;

    // Reset for two cycles
    step(0, '0, 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 0);

    // Single pass-through
    step(1, pkt(0, 0, 32'h1c000000, 32'h02800c21), 1);
    step(0, '0, 1);
    step(0, '0, 1);

    // Fill to full with ID stalled, then a rejected fifth packet, then drain
    for (int i = 0; i < 4; i++) step(1, pkt(0, 0, 32'h1c000000 + 32'(4 * i), 32'h1000 + 32'(i)), 0);
    step(1, pkt(0, 0, 32'h1c000010, 32'h1004), 0);
    for (int i = 0; i < 6; i++) step(0, '0, 1);

    // Push/pop together at occupancy 2 across pointer wrap
    pc = 32'h1c000100;
    for (int i = 0; i < 2; i++) begin step(1, pkt(0, 0, pc, 32'h2000 + pc), 0); pc += 4; end
    for (int i = 0; i < 10; i++) begin step(1, pkt(0, 0, pc, 32'h2000 + pc), 1); pc += 4; end
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Flush with concurrent push, once per flush source
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) step(1, pkt(0, 0, 32'h1c000200 + 32'(4 * i), 32'h3000 + 32'(i)), 0);
      step(1, pkt(0, 0, 32'hdeadbeec, 32'hdeadbeef), 1, k == 0, k == 1, k == 2);
      step(0, '0, 1);
      step(1, pkt(0, 0, 32'h1c000300, 32'h4000 + 32'(k)), 1);
      step(0, '0, 1);
      step(0, '0, 1);
    end

    // Exception packet between ordinary ones
    step(1, pkt(0, 0, 32'h1c000000, 32'h5000), 0);
    step(1, pkt(1, 1, 32'h1c000002, 32'h0), 1);
    step(1, pkt(0, 0, 32'h1c000004, 32'h5001), 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Randomized traffic with occasional flushes and mid-run resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60,
           {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 32'($urandom), 32'($urandom)},
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 1,
           $urandom_range(0, 199) != 0);
    end
    for (int i = 0; i < 6; i++) step(0, '0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
